unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares the single-port unified instruction/data memory of the rv32i core between two requesters: the instruction-fetch port and the load/store data port.
- Serialises accesses with one outstanding transaction at a time and routes each response back to the requester that issued it.
- Data accesses have priority over fetch. A starvation limit guarantees fetch progress.
- Sits between the core and the memory model. It also provides a saturating fetch-stall counter for bench cycle accounting.

Parameters:
- STARVE_LIMIT, 4, consecutive arbitration losses by fetch after which fetch is forced to win the next arbitration (1..15).
- CNT_W, 16, width of the fetch-stall counter.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- i_req  input  1  fetch request; held until i_gnt
- i_addr  input  32  fetch byte address
- i_gnt  output  1  fetch request accepted this cycle
- i_rvalid  output  1  fetch response valid (1-cycle pulse)
- i_rdata  output  32  fetch read data
- d_req  input  1  data request; held until d_gnt
- d_we  input  1  1 = store, 0 = load
- d_addr  input  32  data byte address
- d_be  input  4  byte enables for a store (SB/SH/SW lanes)
- d_wdata  input  32  store data, already lane-aligned
- d_gnt  output  1  data request accepted this cycle
- d_rvalid  output  1  data response valid (load data or store ack)
- d_rdata  output  32  load read data (full word)
- mem_req  output  1  memory request
- mem_we  output  1  memory write
- mem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- mem_be  output  4  byte enables (4'hF for all reads)
- mem_wdata  output  32  write data
- mem_gnt  input  1  memory accepts the request this cycle
- mem_rvalid  input  1  memory response (read data or write ack)
- mem_rdata  input  32  memory read data
- fetch_stall_cnt  output  CNT_W  saturating count of cycles with i_req high and no i_gnt

Behaviour:
- Reset (async, active-low):
  - state=IDLE, owner=NONE, starve_cnt=0, fetch_stall_cnt=0.
  - mem_req, mem_we, i_gnt, d_gnt, i_rvalid, d_rvalid all 0.
  - mem_addr, mem_be, mem_wdata, i_rdata, d_rdata all 0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Arbitration is combinational.
  - If d_req and not (i_req and starve_cnt==STARVE_LIMIT): grant data.
  - Else if i_req: grant fetch.
  - The selected *_gnt is high in this cycle only.
  - On the clock edge, the arbiter registers the winner's addr/we/be/wdata into the mem_* outputs, sets owner, and moves to ISSUE.
  - Fetch is always captured with we=0, be=4'hF. A data load is captured with be=4'hF regardless of d_be.
- ISSUE:
  - mem_req=1 with stable registered fields.
  - When mem_gnt=1: mem_req deasserts on the next edge and the state moves to WAIT.
  - A mem_rvalid in the same cycle as mem_gnt is treated as the response: return to IDLE.
- WAIT: on mem_rvalid, return to IDLE.
- Response routing:
  - {i,d}_rvalid = mem_rvalid AND (state is WAIT, or ISSUE with mem_gnt) AND owner matches. This is combinational, zero added latency.
  - i_rdata/d_rdata = mem_rdata combinationally when the matching rvalid is set, else hold 0.
  - Stores produce d_rvalid as the ack.
- mem_rvalid in IDLE is ignored (no rvalid pulse).
- Throughput and latency:
  - Minimum request-to-response is 2 cycles (gnt at T, mem_req at T+1, mem_gnt+mem_rvalid at T+1 → rvalid at T+1).
  - The next arbitration happens at the earliest in the cycle after the response.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each IDLE arbitration where i_req=1 and data wins.
  - Clears on i_gnt.
  - Unchanged when i_req=0.
- fetch_stall_cnt: increments every cycle with i_req=1 and i_gnt=0, and saturates at all-ones.
- Simultaneous events: when i_req and d_req are both asserted in IDLE, exactly one gnt goes high. The loser's request must remain held and is not lost.
- Reset mid-transaction: the in-flight transaction is abandoned. A subsequent mem_rvalid after reset release, while IDLE, is dropped.
- The address low bits [1:0] are not forwarded. Byte-lane alignment of store data and load extraction are the core's job.

Test Plan:
- Fetch only: i_req=1, i_addr=0x0000_0104, memory returns 0x00A00093 one cycle after mem_gnt → i_gnt at T0, mem_addr=0x104, mem_be=F, mem_we=0, i_rvalid pulse with i_rdata=0x00A00093.
- Store byte:
  - Stimulus: d_req, d_we=1, d_addr=0x203, d_be=4'b1000, d_wdata=0x5A000000.
  - Required: mem_addr=0x200, mem_be=8, mem_wdata=0x5A000000, d_rvalid ack, no i_rvalid.
- Contention: i_req and d_req both held continuously with STARVE_LIMIT=4 → grant order D,D,D,D,I,D,…; fetch_stall_cnt increases by stalled cycles only.
- Back-to-back with memory wait states: mem_gnt delayed 3 cycles, mem_rvalid 2 cycles later → mem_req held 4 cycles with stable fields, then exactly one rvalid to the correct owner, then the next arbitration.
- Load after store to same word: SB 0x11 to 0x200 lane 0, then LB 0x200 → d_rdata[7:0]=0x11, load issued with mem_be=F.
- Reset mid-WAIT: assert reset while in WAIT, release, then pulse mem_rvalid → all outputs 0, no rvalid, fetch_stall_cnt=0, next request is arbitrated normally.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - fetch/data arbiter for the shared single-port rv32i memory
module unified_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req,
    input  logic [31:0]      i_addr,
    output logic             i_gnt,
    output logic             i_rvalid,
    output logic [31:0]      i_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [31:0]      d_addr,
    input  logic [3:0]       d_be,
    input  logic [31:0]      d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [31:0]      d_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_be,
    output logic [31:0]      mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] fetch_stall_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t             r_state;
    state_t             w_next;
    owner_t             r_owner;
    logic [3:0]         r_starve;
    logic [CNT_W-1:0]   r_stall;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [3:0]         r_mem_be;
    logic [31:0]        r_mem_wdata;
    logic               w_i_win;
    logic               w_d_win;
    logic               w_resp;
    logic               w_i_gnt;
    logic               w_d_gnt;

    always_comb begin
        w_next  = r_state;
        w_i_win = 1'b0;
        w_d_win = 1'b0;
        case (r_state)
            IDLE: begin
                // data wins unless fetch has lost STARVE_LIMIT arbitrations in a row
                w_d_win = d_req && !(i_req && (r_starve == LIMIT));
                w_i_win = i_req && !w_d_win;
                if (w_d_win || w_i_win)
                    w_next = ISSUE;
            end
            ISSUE: begin
                if (mem_gnt)
                    w_next = mem_rvalid ? IDLE : WAIT;
            end
            WAIT: begin
                if (mem_rvalid)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_i_gnt = reset & w_i_win;
    assign w_d_gnt = reset & w_d_win;
    assign w_resp  = mem_rvalid && ((r_state == WAIT) || ((r_state == ISSUE) && mem_gnt));

    assign i_gnt     = w_i_gnt;
    assign d_gnt     = w_d_gnt;
    assign i_rvalid  = w_resp && (r_owner == OWN_FETCH);
    assign d_rvalid  = w_resp && (r_owner == OWN_DATA);
    assign i_rdata   = i_rvalid ? mem_rdata : 32'h0;
    assign d_rdata   = d_rvalid ? mem_rdata : 32'h0;

    assign mem_req   = (r_state == ISSUE);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

    assign fetch_stall_cnt = r_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_owner     <= OWN_NONE;
            r_starve    <= 4'd0;
            r_stall     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_be    <= 4'h0;
            r_mem_wdata <= 32'h0;
        end else begin
            r_state <= w_next;

            if (w_d_gnt) begin
                r_owner     <= OWN_DATA;
                r_mem_we    <= d_we;
                r_mem_addr  <= {d_addr[31:2], 2'b00};
                r_mem_be    <= d_we ? d_be : 4'hF;
                r_mem_wdata <= d_we ? d_wdata : 32'h0;
            end else if (w_i_gnt) begin
                r_owner     <= OWN_FETCH;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= {i_addr[31:2], 2'b00};
                r_mem_be    <= 4'hF;
                r_mem_wdata <= 32'h0;
            end else if (w_resp) begin
                r_owner <= OWN_NONE;
            end

            if (w_i_gnt)
                r_starve <= 4'd0;
            else if (w_d_gnt && i_req && (r_starve != LIMIT))
                r_starve <= r_starve + 4'd1;

            if (i_req && !w_i_gnt && (r_stall != {CNT_W{1'b1}}))
                r_stall <= r_stall + 1'b1;
        end
    end

endmodule
